// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage slice: fetch/dispatch width, fetch
// buffer depth, the buffered {pc,inst} entry type and the word-select helper.
`ifndef WAYS
`define WAYS 3
`endif

package fetch_stage_pkg;

  localparam int unsigned WAYS     = `WAYS;
  localparam int unsigned FB_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } FB_ENTRY;

  // Each lane carries its own address, so a lane straddling into the next
  // 8-byte line simply picks a half of its own line.
  function automatic logic [31:0] word_sel(input logic [31:0] addr,
                                           input logic [63:0] line);
    return addr[2] ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch <-> icache bus.
//   proc2Icache_addr  WAYS*32  lane i address (PC + 4*i)
//   proc2Icache_en    WAYS     lane enables
//   Icache_data_out   WAYS*64  line data per lane, same cycle as address
//   Icache_valid_out  WAYS     per-lane hit, same cycle as address
// master = fetch stage, slave = icache.
interface fetch_stage_if #(
  parameter int unsigned WAYS = fetch_stage_pkg::WAYS
);
  logic [WAYS*32-1:0] proc2Icache_addr;
  logic [WAYS-1:0]    proc2Icache_en;
  logic [WAYS*64-1:0] Icache_data_out;
  logic [WAYS-1:0]    Icache_valid_out;

  modport master (
    output proc2Icache_addr, proc2Icache_en,
    input  Icache_data_out, Icache_valid_out
  );

  modport slave (
    input  proc2Icache_addr, proc2Icache_en,
    output Icache_data_out, Icache_valid_out
  );
endinterface

// File: rtl/fetch_stage_buffer.sv
// fetch_buffer: circular FIFO of {pc,inst} entries, up to WAYS enqueued and
// up to WAYS dequeued per cycle.
//   clock, reset  clock / synchronous active-high reset
//   flush         empties the buffer (pointers and count to 0)
//   enq_cnt       number of enq_data lanes written at tail this cycle
//   enq_data      entries to enqueue, lane 0 first
//   deq_cnt       entries popped this cycle (clamped to count)
//   head_data     entries at head..head+WAYS-1
//   count         registered occupancy, 0..FB_DEPTH
module fetch_buffer #(
  parameter int unsigned WAYS     = fetch_stage_pkg::WAYS,
  parameter int unsigned FB_DEPTH = fetch_stage_pkg::FB_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [$clog2(WAYS+1)-1:0]     enq_cnt,
  input  fetch_stage_pkg::FB_ENTRY      enq_data [WAYS],
  input  logic [$clog2(WAYS+1)-1:0]     deq_cnt,
  output fetch_stage_pkg::FB_ENTRY      head_data [WAYS],
  output logic [$clog2(FB_DEPTH):0]     count
);
  import fetch_stage_pkg::*;

  localparam int unsigned PTR_W = $clog2(FB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENQ_W = $clog2(WAYS + 1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, deq_eff;
  FB_ENTRY          mem_q [FB_DEPTH];

  always_comb begin
    deq_eff = (CNT_W'(deq_cnt) > count_q) ? count_q : CNT_W'(deq_cnt);
    head_d  = head_q + PTR_W'(deq_eff);
    tail_d  = tail_q + PTR_W'(enq_cnt);
    count_d = count_q + CNT_W'(enq_cnt) - deq_eff;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      for (int unsigned i = 0; i < WAYS; i++) begin
        if (ENQ_W'(i) < enq_cnt) mem_q[tail_q + PTR_W'(i)] <= enq_data[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < WAYS; i++) begin
      head_data[i] = mem_q[head_q + PTR_W'(i)];
    end
  end

  assign count = count_q;

  // Decode must never pop more than is buffered; the pop is clamped anyway.
  deq_within_count: assert property (
    @(posedge clock) disable iff (reset || flush) CNT_W'(deq_cnt) <= count_q
  );

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: superscalar instruction fetch in front of the icache.
// Holds the PC, presents WAYS consecutive word addresses, accepts the leading
// run of hits, selects each 32-bit word from its 64-bit line and queues
// {pc,inst} into the fetch buffer that feeds decode. Redirect flushes and
// restarts fetch at redirect_pc.
//   clock, reset     clock / synchronous active-high reset
//   redirect_valid   flush and restart at redirect_pc
//   redirect_pc      new PC, bits [1:0] forced to 0
//   icache           fetch_stage_if.master (addr/en out, data/valid in)
//   deq_count        entries decode pops this cycle
//   fb_pc, fb_inst   PC / instruction of head+i
//   fb_valid         thermometer: bit i set iff buffered count > i
module fetch_stage #(
  parameter int unsigned WAYS     = fetch_stage_pkg::WAYS,
  parameter int unsigned FB_DEPTH = fetch_stage_pkg::FB_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  fetch_stage_if.master             icache,
  input  logic [$clog2(WAYS+1)-1:0] deq_count,
  output logic [WAYS*32-1:0]        fb_pc,
  output logic [WAYS*32-1:0]        fb_inst,
  output logic [WAYS-1:0]           fb_valid
);
  import fetch_stage_pkg::*;

  localparam int unsigned PTR_W = $clog2(FB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENQ_W = $clog2(WAYS + 1);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count, free;
  logic [WAYS-1:0]  en, hit;
  logic [ENQ_W-1:0] k;
  logic             run;
  logic [31:0]      lane_addr [WAYS];
  FB_ENTRY          enq_data  [WAYS];
  FB_ENTRY          head_data [WAYS];
  logic             unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Free slots use the registered count only; this cycle's dequeue is not credited.
  assign free = CNT_W'(FB_DEPTH) - count;

  always_comb begin
    for (int unsigned i = 0; i < WAYS; i++) begin
      lane_addr[i]                    = pc_q + (32'(i) << 2);
      en[i]                           = !reset && !redirect_valid && (CNT_W'(i) < free);
      hit[i]                          = en[i] & icache.Icache_valid_out[i];
      icache.proc2Icache_addr[i*32 +: 32] = lane_addr[i];
      icache.proc2Icache_en[i]        = en[i];
      enq_data[i].pc                  = lane_addr[i];
      enq_data[i].inst                = word_sel(lane_addr[i], icache.Icache_data_out[i*64 +: 64]);
    end
  end

  // Accept only the leading run of hits; anything after the first miss is refetched.
  always_comb begin
    k   = '0;
    run = 1'b1;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (run && hit[i]) k = k + ENQ_W'(1);
      else               run = 1'b0;
    end
  end

  always_comb begin
    pc_d = pc_q + (32'(k) << 2);
    if (redirect_valid) pc_d = {redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge clock) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  fetch_buffer #(
    .WAYS     (WAYS),
    .FB_DEPTH (FB_DEPTH)
  ) u_fetch_buffer (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .enq_cnt   (k),
    .enq_data  (enq_data),
    .deq_cnt   (deq_count),
    .head_data (head_data),
    .count     (count)
  );

  always_comb begin
    for (int unsigned i = 0; i < WAYS; i++) begin
      fb_pc[i*32 +: 32]   = head_data[i].pc;
      fb_inst[i*32 +: 32] = head_data[i].inst;
      fb_valid[i]         = count > CNT_W'(i);
    end
  end

endmodule
